change_disp_arbiter: RTL

Round-robin arbiter and sequencer that shares one change dispenser among NUM_REQ vending lanes. It accepts change-due requests from the lanes, issues them one at a time over the dispenser's valid/ready input interface, and tracks each transaction until the dispenser returns to ready. It then reports per-lane completion and error status. It sits between the lane controllers and the single change dispenser instance.

---
 rtl/change_disp_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/change_disp_arbiter.sv
// rtl/change_disp_arbiter.sv - round-robin arbiter sharing one change dispenser among vending lanes
//
// Grants one lane at a time, forwards its change amount to the dispenser over a
// valid/ready handshake, waits for the dispenser to drop and re-raise ready, then
// pulses done_o to the owning lane with err_o qualifying the outcome.
//
// Optional build macro: CHANGE_ARB_AUDIT_EN (coin-pulse audit of the dispensed sum).
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_valid_i / req_amt_i     per-lane request and amount (lane i at [i*AMT_W +: AMT_W])
//   req_ready_o                 one-hot grant to the round-robin winner while idle
//   done_o / err_o              one-cycle completion pulse to owner, error qualifier
//   busy_o / owner_o            transaction in progress, current/last owner index
//   disp_valid_o / disp_amt_o   request and amount to the dispenser
//   disp_ready_i                dispenser ready
//   quarter_i .. penny_i        dispenser coin pulses (audit build only)
module change_disp_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int AMT_W       = 7,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*AMT_W-1:0]   req_amt_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic [NUM_REQ-1:0]         done_o,
    output logic                       err_o,
    output logic                       busy_o,
    output logic [$clog2(NUM_REQ)-1:0] owner_o,
    output logic                       disp_valid_o,
    output logic [AMT_W-1:0]           disp_amt_o,
    input  logic                       disp_ready_i,
    input  logic                       quarter_i,
    input  logic                       dime_i,
    input  logic                       nickel_i,
    input  logic                       penny_i
);

    localparam int OW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t          state, state_next;
    logic [OW-1:0]   rr_ptr;
    logic [AMT_W-1:0] amt_q;
    logic [TW-1:0]   timer;
    logic            seen_low;
    logic            timed_out;
    logic            grant_found;
    logic [OW-1:0]   grant_idx;
    logic [AMT_W-1:0] grant_amt;
    logic [OW:0]     cand_ext;
    logic [OW-1:0]   cand;
    logic            timeout_hit;
    logic            audit_bad;

    // The timer starts at 0 on the first ISSUE cycle, so leaving at
    // TIMEOUT_CYC-1 puts DONE exactly TIMEOUT_CYC cycles after ISSUE entry.
    assign timeout_hit = (timer == TW'(TIMEOUT_CYC - 1));

    // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_ext    = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_ext = {1'b0, rr_ptr} + (OW+1)'(k);
            if (cand_ext >= (OW+1)'(NUM_REQ))
                cand_ext = cand_ext - (OW+1)'(NUM_REQ);
            cand = cand_ext[OW-1:0];
            if (!grant_found && req_valid_i[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        grant_amt = '0;
        for (int k = 0; k < NUM_REQ; k++)
            if (grant_idx == OW'(k))
                grant_amt = req_amt_i[k*AMT_W +: AMT_W];
    end

`ifdef CHANGE_ARB_AUDIT_EN
    logic [AMT_W:0]   audit_sum;
    logic [AMT_W+1:0] coin_val;
    logic [AMT_W+1:0] sum_wide;

    always_comb begin
        coin_val = (quarter_i ? (AMT_W+2)'(25) : '0)
                 + (dime_i    ? (AMT_W+2)'(10) : '0)
                 + (nickel_i  ? (AMT_W+2)'(5)  : '0)
                 + (penny_i   ? (AMT_W+2)'(1)  : '0);
        sum_wide = {1'b0, audit_sum} + coin_val;
    end

    always_ff @(posedge clk) begin
        if (rst || (state == IDLE))
            audit_sum <= '0;
        else if (state == WAIT)
            audit_sum <= sum_wide[AMT_W+1] ? '1 : sum_wide[AMT_W:0];
    end

    assign audit_bad = (audit_sum != {1'b0, amt_q});
`else
    logic unused_coins;
    assign unused_coins = ^{quarter_i, dime_i, nickel_i, penny_i};
    assign audit_bad    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner_o   <= '0;
            amt_q     <= '0;
            timer     <= '0;
            seen_low  <= 1'b0;
            timed_out <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        owner_o   <= grant_idx;
                        amt_q     <= grant_amt;
                        timer     <= '0;
                        seen_low  <= 1'b0;
                        timed_out <= 1'b0;
                    end
                end
                ISSUE: begin
                    timer <= timer + TW'(1);
                    if (timeout_hit) timed_out <= 1'b1;
                end
                WAIT: begin
                    timer <= timer + TW'(1);
                    if (!disp_ready_i) seen_low <= 1'b1;
                    if (timeout_hit) timed_out <= 1'b1;
                end
                DONE: begin
                    rr_ptr <= (owner_o == OW'(NUM_REQ - 1)) ? '0 : owner_o + OW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next   = state;
        req_ready_o  = '0;
        done_o       = '0;
        err_o        = 1'b0;
        disp_valid_o = 1'b0;
        disp_amt_o   = '0;
        busy_o       = (state != IDLE);
        case (state)
            IDLE: begin
                // Gated by rst so a lane never sees an accept the FSM discards.
                if (grant_found && !rst)
                    req_ready_o[grant_idx] = 1'b1;
                if (grant_found)
                    state_next = (grant_amt == '0) ? DONE : ISSUE;
            end
            ISSUE: begin
                disp_valid_o = 1'b1;
                disp_amt_o   = amt_q;
                if (timeout_hit)       state_next = DONE;
                else if (disp_ready_i) state_next = WAIT;
            end
            WAIT: begin
                if (timeout_hit)                   state_next = DONE;
                else if (seen_low && disp_ready_i) state_next = DONE;
            end
            DONE: begin
                done_o[owner_o] = 1'b1;
                err_o           = timed_out | audit_bad;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
